// File: rtl/med_filter_proc.sv
// 3x3 median filter for an 8-bit vsync/href framed grayscale stream.
// Replicate-edge borders; output lags one line plus a 4-cycle pipeline.
module med_filter_proc #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_img_vsync,
    input  logic       per_img_href,
    input  logic [7:0] per_img_gray,
    output logic       post_img_vsync,
    output logic       post_img_href,
    output logic [7:0] post_img_gray
);

    localparam int CW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int RW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_VDISP - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_LAST} state_t;

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    state_t state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0] gap;
    logic vs_d, vs_rise, run, p_vld, lb_wr, fa;

    logic [7:0] lb_a [IMG_HDISP];
    logic [7:0] lb_b [IMG_HDISP];

    logic [2:0][7:0] cin, rgt, w0, w1;
    logic [2:0][7:0] s1_lo, s1_md, s1_hi;
    logic [7:0] s2_a, s2_b, s2_c;
    logic pv_d, s1_v, s2_v;
    logic [2:0] vs_pipe;

    assign vs_rise = per_img_vsync & ~vs_d;
    assign run     = (state == S_RUN) & ~vs_rise;
    assign lb_wr   = run & per_img_href;
    assign p_vld   = (lb_wr & (row != '0)) | ((state == S_LAST) & ~vs_rise);
    assign fa      = vs_rise | (state != S_IDLE);

    always_comb begin
        state_nx = state;
        if (vs_rise) begin
            state_nx = S_RUN;
        end else begin
            unique case (state)
                S_IDLE: state_nx = S_IDLE;
                S_RUN:  if (per_img_href && col == COL_LAST && row == ROW_LAST)
                            state_nx = S_GAP;
                S_GAP:  if (gap == 4'd9) state_nx = S_LAST;
                S_LAST: if (col == COL_LAST) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // vs_d resets high so a vsync already high at reset release is not a new frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            vs_d  <= 1'b1;
            col   <= '0;
            row   <= '0;
            gap   <= '0;
        end else begin
            state <= state_nx;
            vs_d  <= per_img_vsync;
            if (vs_rise) begin
                col <= '0;
                row <= '0;
                gap <= '0;
            end else begin
                unique case (state)
                    S_RUN: begin
                        gap <= '0;
                        if (per_img_href) begin
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + RW'(1);
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    S_GAP:  gap <= gap + 4'd1;
                    S_LAST: col <= (col == COL_LAST) ? '0 : col + CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Row 0 seeds both buffers so the top border replicates itself
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lb_a[col] <= (row == '0) ? per_img_gray : lb_b[col];
            lb_b[col] <= per_img_gray;
        end
    end

    always_comb begin
        cin[0] = lb_a[col];
        cin[1] = lb_b[col];
        cin[2] = (state == S_LAST) ? lb_b[col] : per_img_gray;
        rgt    = p_vld ? cin : w1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w0   <= '0;
            w1   <= '0;
            pv_d <= 1'b0;
        end else begin
            pv_d <= p_vld;
            if (p_vld) begin
                w1 <= cin;
                w0 <= (col == '0) ? cin : w1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_lo <= '0;
            s1_md <= '0;
            s1_hi <= '0;
            s1_v  <= 1'b0;
            s2_a  <= '0;
            s2_b  <= '0;
            s2_c  <= '0;
            s2_v  <= 1'b0;
            post_img_href <= 1'b0;
            post_img_gray <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_lo[i] <= min2(min2(w0[i], w1[i]), rgt[i]);
                s1_md[i] <= med3(w0[i], w1[i], rgt[i]);
                s1_hi[i] <= max2(max2(w0[i], w1[i]), rgt[i]);
            end
            s1_v <= pv_d;
            s2_a <= max2(max2(s1_lo[0], s1_lo[1]), s1_lo[2]);
            s2_b <= med3(s1_md[0], s1_md[1], s1_md[2]);
            s2_c <= min2(min2(s1_hi[0], s1_hi[1]), s1_hi[2]);
            s2_v <= s1_v;
            post_img_href <= s2_v;
            post_img_gray <= s2_v ? med3(s2_a, s2_b, s2_c) : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_pipe        <= '0;
            post_img_vsync <= 1'b0;
        end else begin
            vs_pipe        <= {vs_pipe[1:0], fa};
            post_img_vsync <= vs_pipe[2];
        end
    end

endmodule

// File: tb/tb_med_filter_proc.sv
// Bench for med_filter_proc: pattern and random frames against a
// sort-based replicate-border 3x3 median reference.
module tb_med_filter_proc;

    localparam int H = 12;
    localparam int V = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       per_img_vsync = 1'b0;
    logic       per_img_href = 1'b0;
    logic [7:0] per_img_gray = 8'd0;
    logic       post_img_vsync;
    logic       post_img_href;
    logic [7:0] post_img_gray;

    always #5 clk = ~clk;

    med_filter_proc #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .per_img_vsync (per_img_vsync),
        .per_img_href  (per_img_href),
        .per_img_gray  (per_img_gray),
        .post_img_vsync(post_img_vsync),
        .post_img_href (post_img_href),
        .post_img_gray (post_img_gray)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    logic [7:0] img [V][H];

    logic [7:0] obs_pix [$];
    int obs_cyc [$];
    int outside = 0;
    int n_fall = 0;
    int vrise_cyc = -1;
    int vfall_cyc = -1;
    bit prev_vs = 1'b0;

    always @(negedge clk) begin
        if (post_img_href) begin
            obs_pix.push_back(post_img_gray);
            obs_cyc.push_back(cyc);
            if (!post_img_vsync) outside++;
        end
        if (post_img_vsync && !prev_vs) vrise_cyc = cyc;
        if (!post_img_vsync && prev_vs) begin
            vfall_cyc = cyc;
            n_fall++;
        end
        prev_vs = post_img_vsync;
    end

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [7:0] ref_px(input int r, input int c);
        logic [7:0] v [9];
        logic [7:0] t;
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[k] = img[clampi(r + dr, V - 1)][clampi(c + dc, H - 1)];
                k++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j];
                    v[j] = v[j+1];
                    v[j+1] = t;
                end
        return v[4];
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                case (kind)
                    0: img[r][c] = 8'h80;
                    1: img[r][c] = (r == 3 && c == 5) ? 8'hFF : 8'h00;
                    2: img[r][c] = (r == 0 && c == 0) ? 8'hFF : 8'h00;
                    3: img[r][c] = (r < 2 && c < 2) ? 8'hFF : 8'h00;
                    4: img[r][c] = 8'((c * 23) % 256);
                    5: img[r][c] = ((r + c) % 2 == 0) ? 8'h00 : 8'hFF;
                    default: img[r][c] = 8'($urandom_range(0, 255));
                endcase
    endtask

    task automatic send_line(input int r, output int first_cyc);
        for (int c = 0; c < H; c++) begin
            @(negedge clk);
            per_img_href = 1'b1;
            per_img_gray = img[r][c];
            if (c == 0) first_cyc = cyc;
        end
        repeat (12) begin
            @(negedge clk);
            per_img_href = 1'b0;
            per_img_gray = 8'd0;
        end
    endtask

    task automatic run_frame(input string name);
        int base, fb, ob, vs_at, in1, tmp, got_n, last;
        base = obs_pix.size();
        fb = n_fall;
        ob = outside;
        in1 = 0;
        @(negedge clk);
        per_img_vsync = 1'b1;
        vs_at = cyc;
        repeat (3) @(negedge clk);
        for (int r = 0; r < V; r++) begin
            send_line(r, tmp);
            if (r == 1) in1 = tmp;
        end
        per_img_vsync = 1'b0;
        for (int i = 0; i < 300 && n_fall == fb; i++) @(negedge clk);
        @(negedge clk);
        chk({name, " vsync_fall_seen"}, int'(n_fall > fb), 1);
        got_n = obs_pix.size() - base;
        chk({name, " npix"}, got_n, H * V);
        chk({name, " href_outside_vsync"}, outside - ob, 0);
        chk({name, " vsync_rise_lag"}, vrise_cyc - vs_at, 4);
        if (got_n > 0) begin
            last = obs_pix.size() - 1;
            chk({name, " href_lag"}, obs_cyc[base] - in1, 4);
            chk({name, " vsync_fall_after_last"}, vfall_cyc - obs_cyc[last], 1);
        end
        for (int r = 0; r < V && (r + 1) * H <= got_n; r++)
            chk($sformatf("%s row%0d_contig", name, r),
                obs_cyc[base + r * H + H - 1] - obs_cyc[base + r * H], H - 1);
        for (int i = 0; i < got_n && i < H * V; i++)
            chk($sformatf("%s px(%0d,%0d)", name, i / H, i % H),
                obs_pix[base + i], ref_px(i / H, i % H));
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int tmp, sz;
        repeat (3) @(negedge clk);
        chk("reset vsync", post_img_vsync, 0);
        chk("reset href", post_img_href, 0);
        chk("reset gray", post_img_gray, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fill(0); run_frame("const80");
        fill(1); run_frame("impulse");
        fill(2); run_frame("corner_imp");
        fill(3); run_frame("corner_2x2");
        fill(4); run_frame("ramp");
        fill(5); run_frame("checker");
        fill(6); run_frame("rand0");
        fill(6); run_frame("rand1");

        fill(6);
        @(negedge clk);
        per_img_vsync = 1'b1;
        repeat (3) @(negedge clk);
        send_line(0, tmp);
        send_line(1, tmp);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            per_img_href = 1'b1;
            per_img_gray = img[2][c];
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst vsync", post_img_vsync, 0);
        chk("midrst href", post_img_href, 0);
        chk("midrst gray", post_img_gray, 0);
        rst_n = 1'b1;
        per_img_href = 1'b0;
        per_img_gray = 8'd0;
        sz = obs_pix.size();
        repeat (10) @(negedge clk);
        per_img_vsync = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst quiet_pix", obs_pix.size() - sz, 0);
        fill(6); run_frame("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
